// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, reads instruction memory with a
// req/ready handshake, latches the word into an instruction register and
// offers it to the multicycle controller with a valid/ready handshake.
//
// Handshakes: a transfer happens on a rising edge where the producer's
// valid-like signal and the consumer's ready are both 1. For memory that is
// imem_req & imem_ready; for the controller it is instr_valid & dec_ready.
// While its valid-like signal is high, the producer holds its payload
// (imem_addr, or instr/op/funct/pc) stable. A producer never drops that
// signal except through a transfer, a redirect or reset.
module instr_fetch #(
  parameter int unsigned          PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic [PC_WIDTH-1:0] imem_rdata,
  output logic                instr_valid,
  input  logic                dec_ready,
  output logic [PC_WIDTH-1:0] instr,
  output logic [5:0]          op,
  output logic [5:0]          funct,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_plus4,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic [15:0]         fetch_count,
  output logic                dbg_state
);

  // REQ: a memory read is outstanding at pc. HOLD: instr holds a valid word.
  typedef enum logic {
    S_REQ  = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] instr_q, instr_d;
  logic [15:0]         cnt_q, cnt_d;

  // Register update; reset abandons everything immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: fetch / hold, with redirect overriding the PC and state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_REQ: begin
        // A redirect in the same cycle lets the memory transfer finish but
        // throws the returned word away.
        if (imem_ready && !redirect) begin
          instr_d = imem_rdata;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        // Consumption still counts when it coincides with a redirect.
        if (dec_ready) begin
          cnt_d   = cnt_q + 16'd1;
          pc_d    = pc_plus4;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
    if (redirect) begin
      pc_d    = {redirect_pc[PC_WIDTH-1:2], 2'b00};
      state_d = S_REQ;
    end
  end

  // Outputs; the request is gated by reset so it is low during reset.
  always_comb begin
    imem_req    = (state_q == S_REQ) && reset;
    imem_addr   = pc_q;
    instr_valid = (state_q == S_HOLD);
    instr       = instr_q;
    op          = instr_q[31:26];
    funct       = instr_q[5:0];
    pc          = pc_q;
    pc_plus4    = pc_q + PC_WIDTH'(4);
    fetch_count = cnt_q;
    dbg_state   = state_q;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of the multicycle controller.
- Holds the PC and issues req/ready reads to instruction memory.
- Latches each returned word into an instruction register and presents it with a valid/ready handshake.
- Supplies `op`/`funct` to the controller and accepts branch/jump redirects from the datapath.

Parameters:
- `PC_WIDTH`, default 32: width of the PC, memory address and instruction word.
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset. Bits [1:0] must be 0.

Ports:
- `clk`  input  1: system clock, rising edge.
- `reset`  input  1: asynchronous, active-low reset.
- `imem_req`  output  1: instruction memory read request.
- `imem_addr`  output  PC_WIDTH: read address, equal to `pc`.
- `imem_ready`  input  1: memory returns `imem_rdata` this cycle. Meaningful only while `imem_req`=1.
- `imem_rdata`  input  PC_WIDTH: instruction word.
- `instr_valid`  output  1: `instr`/`op`/`funct`/`pc` hold a valid instruction.
- `dec_ready`  input  1: controller consumes the current instruction.
- `instr`  output  PC_WIDTH: instruction register.
- `op`  output  6: `instr[31:26]`.
- `funct`  output  6: `instr[5:0]`.
- `pc`  output  PC_WIDTH: address of the instruction in `instr`, or of the pending fetch.
- `pc_plus4`  output  PC_WIDTH: `pc`+4, combinational.
- `redirect`  input  1: branch/jump taken; load `redirect_pc`.
- `redirect_pc`  input  PC_WIDTH: target address. Bits [1:0] are ignored and forced to 00.
- `fetch_count`  output  16: number of instructions accepted by the controller.

Behaviour:
- Reset (`reset`=0, asynchronous) sets all state:
  - state=REQ, `pc`=RESET_PC, `instr`=0, `instr_valid`=0, `fetch_count`=0.
  - `imem_req` is 0 while reset is asserted.
- `imem_req` = (state==REQ) and reset deasserted. `imem_addr` = `pc`.
- State REQ:
  - `imem_req`=1.
  - A transfer occurs in a cycle with `imem_ready`=1: next edge `instr`<=`imem_rdata`, `instr_valid`<=1, go to HOLD.
  - If `imem_ready`=0, stay in REQ with the address held stable.
- State HOLD:
  - `instr_valid`=1. `instr` and `pc` are held stable until consumed.
  - On `dec_ready`=1: next edge `instr_valid`<=0, `pc`<=`pc`+4, `fetch_count`<=`fetch_count`+1, go to REQ.
- Redirect (highest priority, any state):
  - Next edge: `pc`<=`{redirect_pc[PC_WIDTH-1:2],2'b00}`, `instr_valid`<=0, go to REQ.
  - REQ with `imem_ready`=1 in the same cycle: the memory transfer completes, but the data is discarded and `instr` is unchanged.
  - HOLD with `dec_ready`=1 in the same cycle: the instruction counts as consumed (`fetch_count` increments), but `pc` takes the redirect target, not `pc`+4.
- `instr` is not cleared when `instr_valid` falls; only reset clears it. `op`/`funct` are valid only while `instr_valid`=1.
- Arithmetic:
  - `pc`+4 wraps modulo 2^PC_WIDTH (FFFF_FFFC -> 0000_0000), no flag.
  - `fetch_count` wraps FFFF -> 0000.
- Latency and throughput:
  - First `imem_req` is in the first cycle after reset release.
  - `instr_valid` rises one cycle after the ready cycle.
  - Best case is one instruction per 2 cycles.
- Reset mid-operation: all state is abandoned immediately. After release, fetch restarts at RESET_PC.
- No outstanding memory requests exist outside REQ. Memory must not assert `imem_ready` when `imem_req`=0; the block ignores it if it does.

Test Plan:
- Reset release with `imem_ready` tied 1, `imem_rdata`=32'h0000_0020, `dec_ready`=1:
  - `imem_req` is seen at `pc`=0.
  - `instr_valid` is seen at cycle 2 with `op`=0, `funct`=6'h20.
  - Next request is at `pc`=4.
  - `fetch_count` is 1 after the handshake.
- Memory delays `imem_ready` by 3 cycles:
  - `imem_req` stays 1 and `imem_addr` stays 0 for all 4 cycles.
  - `instr_valid` rises exactly one cycle after `imem_ready`.
- `dec_ready`=0 for 5 cycles in HOLD:
  - `instr`, `pc` and `instr_valid`=1 stay stable and `imem_req`=0.
  - `dec_ready`=1 then advances `pc` by 4.
- `redirect`=1 with `redirect_pc`=32'h0000_1003 in REQ while `imem_ready`=1:
  - Data is discarded and `instr` is unchanged.
  - Next `imem_addr`=32'h0000_1000.
- `redirect` together with `dec_ready` in HOLD at `pc`=8, target 32'h40:
  - `fetch_count` increments.
  - Next `pc`=32'h40, not 32'hC.
- Additional coverage:
  - PC wrap: RESET_PC=32'hFFFF_FFFC, one accepted instruction -> next `imem_addr`=0.
  - Reset asserted mid-HOLD: `instr_valid` drops with no clock edge.
